semafor_directie: RTL

//  Light sequencer for one vehicle approach (E/N/S/V); one instance per approach, below the junction controller.
//  A request/done handshake from the controller starts one green->yellow->clearance-red cycle.

---
 rtl/semafor_directie.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/semafor_directie.sv
// Light sequencer for one vehicle approach: runs green -> yellow -> clearance red
// on a four-phase start/done handshake, and owns the blinking-yellow service mode.
module semafor_directie #(
  parameter int unsigned SEC        = 10000000,
  parameter int unsigned GREEN_SEC  = 10,
  parameter int unsigned YELLOW_SEC = 3,
  parameter int unsigned CLEAR_SEC  = 1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic service_i,
  input  logic start_i,
  output logic done_o,
  output logic busy_o,
  output logic verde_o,
  output logic galben_o,
  output logic rosu_o,
  output logic service_o
);

  localparam int unsigned MAX_GY  = (GREEN_SEC > YELLOW_SEC) ? GREEN_SEC : YELLOW_SEC;
  localparam int unsigned MAX_SEC = (MAX_GY > CLEAR_SEC) ? MAX_GY : CLEAR_SEC;
  localparam int unsigned PW      = $clog2(SEC);
  localparam int unsigned SW      = $clog2(MAX_SEC + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(SEC - 1);
  localparam logic [PW-1:0] PRESC_HALF  = PW'(SEC / 2);
  localparam logic [SW-1:0] GREEN_LAST  = SW'(GREEN_SEC - 1);
  localparam logic [SW-1:0] YELLOW_LAST = SW'(YELLOW_SEC - 1);
  localparam logic [SW-1:0] CLEAR_LAST  = SW'(CLEAR_SEC - 1);

  typedef enum logic [2:0] {
    RED_WAIT = 3'd0,
    GREEN    = 3'd1,
    YELLOW   = 3'd2,
    CLEAR    = 3'd3,
    DONE     = 3'd4,
    SERVICE  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   sec_q, sec_d;

  logic            svc_meta_q, svc_meta_d;
  logic            svc_sync_q, svc_sync_d;
  logic            svc_prev_q, svc_prev_d;
  logic            svc_rise;

  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            verde_q, verde_d;
  logic            galben_q, galben_d;
  logic            rosu_q, rosu_d;
  logic            service_q, service_d;

  logic [SW-1:0]   sec_last;
  logic            presc_wrap;
  logic            phase_end;

  // Two flops resynchronise the raw button; the third only remembers the last
  // synchronised level so a rising edge lasts exactly one cycle.
  always_comb begin
    svc_meta_d = service_i;
    svc_sync_d = svc_meta_q;
    svc_prev_d = svc_sync_q;
    svc_rise   = svc_sync_q & ~svc_prev_q;
  end

  always_comb begin
    unique case (state_q)
      GREEN:   sec_last = GREEN_LAST;
      YELLOW:  sec_last = YELLOW_LAST;
      CLEAR:   sec_last = CLEAR_LAST;
      default: sec_last = '0;
    endcase
    presc_wrap = (presc_q == PRESC_LAST);
    phase_end  = presc_wrap && (sec_q == sec_last);
  end

  // NOTE: every variable gets a default at the top of a combinational block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    sec_d   = presc_wrap ? sec_q + 1'b1 : sec_q;

    unique case (state_q)
      RED_WAIT: if (start_i)   state_d = GREEN;
      GREEN:    if (phase_end) state_d = YELLOW;
      YELLOW:   if (phase_end) state_d = CLEAR;
      CLEAR:    if (phase_end) state_d = DONE;
      DONE:     if (!start_i)  state_d = RED_WAIT;
      SERVICE:  sec_d = '0;
      default:  state_d = RED_WAIT;
    endcase

    // A service toggle overrides any handshake decision taken this cycle.
    if (svc_rise) begin
      state_d = (state_q == SERVICE) ? RED_WAIT : SERVICE;
    end

    // Clearing on entry makes every timed phase start from a whole second.
    if ((state_d != state_q) || (state_q == RED_WAIT) || (state_q == DONE)) begin
      presc_d = '0;
      sec_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge.
  always_comb begin
    verde_d   = (state_d == GREEN);
    galben_d  = (state_d == YELLOW) ||
                ((state_d == SERVICE) && (presc_d < PRESC_HALF));
    rosu_d    = (state_d == RED_WAIT) || (state_d == CLEAR) || (state_d == DONE);
    busy_d    = (state_d == GREEN) || (state_d == YELLOW) || (state_d == CLEAR);
    done_d    = (state_d == DONE);
    service_d = (state_d == SERVICE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= RED_WAIT;
      presc_q    <= '0;
      sec_q      <= '0;
      svc_meta_q <= 1'b0;
      svc_sync_q <= 1'b0;
      svc_prev_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      verde_q    <= 1'b0;
      galben_q   <= 1'b0;
      rosu_q     <= 1'b1;
      service_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      svc_meta_q <= svc_meta_d;
      svc_sync_q <= svc_sync_d;
      svc_prev_q <= svc_prev_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      verde_q    <= verde_d;
      galben_q   <= galben_d;
      rosu_q     <= rosu_d;
      service_q  <= service_d;
    end
  end

  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign verde_o   = verde_q;
  assign galben_o  = galben_q;
  assign rosu_o    = rosu_q;
  assign service_o = service_q;

endmodule
